fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Consumer and controller of `program_counter`. Reads `out` as the fetch address, runs a req/ack read on instruction memory, and presents the fetched word to decode through a valid/ready handshake.
- Drives `program_counter` back: one-cycle `enable` pulses to advance it and one-cycle `load`/`data` pulses to redirect it on branches.
- Sits between `program_counter`, instruction memory and the decode stage.

Parameters:
- W, 4, PC/address width; must match `program_counter`.
- IW, 8, instruction word width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_in  in  W  current PC; connects to `program_counter.out`.
- pc_enable  out  1  increment pulse; connects to `program_counter.enable`.
- pc_load  out  1  load pulse; connects to `program_counter.load`.
- pc_data  out  W  load value; connects to `program_counter.data`.
- mem_req  out  1  memory read request.
- mem_addr  out  W  read address, stable while mem_req=1.
- mem_ack  in  1  read complete; mem_rdata valid at the same edge.
- mem_rdata  in  IW  read data.
- instr  out  IW  fetched instruction.
- instr_valid  out  1  instr holds a valid word.
- instr_ready  in  1  decode accepts instr.
- branch_req  in  1  redirect request, sampled each edge.
- branch_target  in  W  redirect address.
- halt  in  1  stop issuing new fetches.

Behaviour:
- Reset (sync) applies regardless of state: state=IDLE, flush=0, and all outputs =0 (mem_req, mem_addr, instr, instr_valid, pc_enable, pc_load, pc_data). An in-flight memory request is abandoned; mem_req drops the cycle after the reset edge.
- States: IDLE, SETUP, REQ, HOLD, REDIRECT.
- IDLE: if halt=0 → SETUP.
- SETUP (exactly 1 cycle): at its exit edge, mem_addr←pc_in and the FSM goes to REQ.
- REQ: mem_req=1 and mem_addr held.
  - Edge with mem_ack=1 and flush=0: instr←mem_rdata, instr_valid←1, → HOLD. pc_enable=1 for the first HOLD cycle only.
  - Edge with mem_ack=1 and flush=1: data discarded, flush←0, → SETUP. No pc_enable.
- HOLD: instr_valid=1 until an edge with instr_ready=1. At that edge instr_valid←0, then → IDLE if halt=1, else → SETUP. instr holds its last value after it is consumed.
- Latency: pc_enable or pc_load is issued ≥1 cycle before SETUP exits, so mem_addr always sees the updated PC.
- Zero-wait memory, always-ready decode: one instruction per 3 cycles (SETUP, REQ, HOLD).
- Branch (branch_req=1 at an edge), handled by state:
  - IDLE: pc_data←branch_target, pc_load=1 for 1 cycle, stay IDLE.
  - SETUP or HOLD: instr_valid←0 (the instruction is flushed even if instr_ready=1 at the same edge) → REDIRECT.
  - REQ without mem_ack: flush←1, pc_data←target, pc_load=1 for 1 cycle. mem_req stays high until ack, since the transaction is never dropped.
  - REQ with mem_ack at the same edge: data discarded → REDIRECT.
- REDIRECT (1 cycle): pc_load=1, pc_data=target latched at the branch edge → SETUP.
- Priority: reset > branch > ack/ready.
- pc_enable and pc_load are never high in the same cycle; a branch at the ack edge suppresses pc_enable.
- Halt never aborts REQ or HOLD; it is sampled only in IDLE and on the HOLD exit edge.
- Address wrap: pc_in wraps inside `program_counter` (4'hF→4'h0); this block applies no width arithmetic.

Test Plan:
- Reset, pc_in=0, 0-wait memory returning rdata=8'hA0+addr, ready=1 → fetch at 0: mem_addr=0 in REQ, instr=8'hA0, instr_valid for 1 cycle, pc_enable single pulse, next mem_addr=1; one instr per 3 cycles.
- Memory acks 3 cycles after req → mem_req held 3 cycles with mem_addr constant; exactly one pc_enable per instruction.
- instr_ready=0 for 5 cycles in HOLD → instr and instr_valid=1 stable for 5 cycles; no new mem_req until ready.
- branch_req with target=4'hC while REQ awaits ack → pc_load pulse with pc_data=4'hC; acked word discarded (instr_valid stays 0); next mem_addr=4'hC.
- branch at the same edge as mem_ack, target=4'h3 → no pc_enable, REDIRECT, next fetch mem_addr=3; pc_in 4'hF incrementing wraps to 0 and is fetched next.
- reset asserted mid-REQ → all outputs 0 the next cycle; halt=1 held after reset → stays IDLE with mem_req=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives program_counter, runs req/ack instruction reads and
// hands fetched words to decode over a valid/ready handshake.
module fetch_sequencer #(
    parameter int W  = 4,
    parameter int IW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  pc_in,
    output logic          pc_enable,
    output logic          pc_load,
    output logic [W-1:0]  pc_data,
    output logic          mem_req,
    output logic [W-1:0]  mem_addr,
    input  logic          mem_ack,
    input  logic [IW-1:0] mem_rdata,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          branch_req,
    input  logic [W-1:0]  branch_target,
    input  logic          halt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_REQ,
        S_HOLD,
        S_REDIRECT
    } state_t;

    state_t        r_state;
    logic          r_flush;
    logic          r_pc_enable;
    logic          r_pc_load;
    logic [W-1:0]  r_pc_data;
    logic          r_mem_req;
    logic [W-1:0]  r_mem_addr;
    logic [IW-1:0] r_instr;
    logic          r_instr_valid;

    state_t        w_state;
    logic          w_flush;
    logic          w_pc_enable;
    logic          w_pc_load;
    logic [W-1:0]  w_pc_data;
    logic [W-1:0]  w_mem_addr;
    logic [IW-1:0] w_instr;
    logic          w_instr_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_flush       <= 1'b0;
            r_pc_enable   <= 1'b0;
            r_pc_load     <= 1'b0;
            r_pc_data     <= '0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_flush       <= w_flush;
            r_pc_enable   <= w_pc_enable;
            r_pc_load     <= w_pc_load;
            r_pc_data     <= w_pc_data;
            r_mem_req     <= (w_state == S_REQ);
            r_mem_addr    <= w_mem_addr;
            r_instr       <= w_instr;
            r_instr_valid <= w_instr_valid;
        end
    end

    // Pulse outputs are registered, so every pulse is decided at the edge
    // that precedes the cycle in which it is visible.
    always_comb begin
        w_state       = r_state;
        w_flush       = r_flush;
        w_pc_enable   = 1'b0;
        w_pc_load     = 1'b0;
        w_pc_data     = r_pc_data;
        w_mem_addr    = r_mem_addr;
        w_instr       = r_instr;
        w_instr_valid = r_instr_valid;

        case (r_state)
            S_IDLE: begin
                if (branch_req) begin
                    w_pc_data = branch_target;
                    w_pc_load = 1'b1;
                end else if (!halt) begin
                    w_state = S_SETUP;
                end
            end
            S_SETUP: begin
                if (branch_req) begin
                    w_instr_valid = 1'b0;
                    w_pc_data     = branch_target;
                    w_pc_load     = 1'b1;
                    w_state       = S_REDIRECT;
                end else begin
                    w_mem_addr = pc_in;
                    w_state    = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    w_flush = 1'b0;
                    if (branch_req) begin
                        w_pc_data = branch_target;
                        w_pc_load = 1'b1;
                        w_state   = S_REDIRECT;
                    end else if (r_flush) begin
                        w_state = S_SETUP;
                    end else begin
                        w_instr       = mem_rdata;
                        w_instr_valid = 1'b1;
                        w_pc_enable   = 1'b1;
                        w_state       = S_HOLD;
                    end
                end else if (branch_req) begin
                    // The bus transaction cannot be dropped: remember to discard it.
                    w_flush   = 1'b1;
                    w_pc_data = branch_target;
                    w_pc_load = 1'b1;
                end
            end
            S_HOLD: begin
                if (branch_req) begin
                    w_instr_valid = 1'b0;
                    w_pc_data     = branch_target;
                    w_pc_load     = 1'b1;
                    w_state       = S_REDIRECT;
                end else if (instr_ready) begin
                    w_instr_valid = 1'b0;
                    w_state       = halt ? S_IDLE : S_SETUP;
                end
            end
            S_REDIRECT: begin
                w_state = S_SETUP;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign pc_enable   = r_pc_enable;
    assign pc_load     = r_pc_load;
    assign pc_data     = r_pc_data;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;

endmodule
